data_mem_arbiter: RTL
=====================

Name: data_mem_arbiter

Overview:
- Shares the single-port data RAM (`reg_file` instance holding data memory) between two requesters.
  - CPU: the processor datapath load/store unit.
  - DBG: the debug/UART unit, which dumps or patches memory.
- Arbitrates per cycle, drives the RAM control/address/data lines, and routes the registered read data back to the requester that issued the read.
- Optional DBG burst lock gives contiguous dumps, with a bound so the CPU is never starved.

Parameters:
- ADDR_W, 11, RAM address width.
- DATA_W, 16, RAM data width.
- MAX_LOCK, 64, maximum consecutive DBG grants while locked before CPU is forced a slot (must be at least 1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request, held until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU access accepted this cycle (combinational).
- cpu_rvalid  out  1  CPU read data valid (one cycle after read grant).
- cpu_rdata  out  DATA_W  CPU read data.
- dbg_req  in  1  DBG access request.
- dbg_we  in  1  1 = write.
- dbg_addr  in  ADDR_W  DBG address.
- dbg_wdata  in  DATA_W  DBG write data.
- dbg_lock  in  1  request burst priority for DBG.
- dbg_gnt  out  1  DBG access accepted this cycle.
- dbg_rvalid  out  1  DBG read data valid.
- dbg_rdata  out  DATA_W  DBG read data.
- mem_wr_en  out  1  to RAM wr_en.
- mem_rd_en  out  1  to RAM rd_en.
- mem_addr  out  ADDR_W  to RAM addr.
- mem_w_data  out  DATA_W  to RAM w_data.
- mem_r_data  in  DATA_W  from RAM r_data; valid the cycle after rd_en is sampled.

Behaviour:
- Reset (async, active-high):
  - state = ARB, rr_ptr = CPU, lock_cnt = 0, rtag_valid = 0.
  - All gnt, rvalid, mem_wr_en and mem_rd_en are 0.
  - mem_addr, mem_w_data, cpu_rdata and dbg_rdata are 0.
- Grant logic:
  - At most one grant per cycle. Grant is combinational from req, state and rr_ptr.
  - Exactly one of gnt/idle drives the mem bus in a given cycle.
- Mem bus drive:
  - Granted requester's addr drives mem_addr, its wdata drives mem_w_data.
  - mem_wr_en = we. mem_rd_en = !we.
  - With no grant, mem_wr_en = mem_rd_en = 0 and addr/data = 0.
- State ARB:
  - Only one req: that requester is granted.
  - Both req: grant rr_ptr's side.
  - After any grant, rr_ptr points at the other requester.
  - DBG granted with dbg_lock = 1: go to DBG_LOCKED with lock_cnt = 1.
- State DBG_LOCKED:
  - CPU is never granted. DBG is granted whenever dbg_req = 1.
  - Each DBG grant increments lock_cnt.
  - dbg_lock = 0 (sampled at the edge): return to ARB and clear lock_cnt.
  - lock_cnt == MAX_LOCK at a grant edge: go to ARB with rr_ptr = CPU and lock_cnt = 0.
    - In that ARB cycle, CPU wins any conflict.
    - DBG may re-lock only through a later ARB grant.
  - dbg_req = 0 while locked: no grant; stay locked and hold lock_cnt.
- Read return:
  - On a read grant, register rtag_valid = 1 and rtag = granted side.
  - Next cycle: the matching side asserts rvalid for 1 cycle, and its rdata = mem_r_data.
  - The other side's rdata holds its last value.
  - Back-to-back reads are fully pipelined, one per cycle.
- Writes: no response beyond gnt; the write completes at the grant edge.
- Simultaneous events:
  - A grant in the same cycle as a pending rvalid is legal (independent pipeline stage).
  - Reset mid-burst or mid-read: the pending rvalid is dropped, not delivered.
- Requesters must hold req/we/addr/wdata stable until gnt. The arbiter does not latch inputs.

Decomposition:
- Shared package `mem_arb_pkg`:
  - state encoding ARB / DBG_LOCKED.
  - requester id constants REQ_CPU = 0, REQ_DBG = 1.
- One natural sub-module: `rr_grant2`, the two-way round-robin grant with priority override.
- The lock FSM and read-tag pipe stay in the top.

Test Plan:
- CPU alone, no DBG: write 0xBEEF to addr 5, then read addr 5.
  - Expect cpu_gnt both cycles.
  - cpu_rvalid=1 one cycle after the read grant with cpu_rdata=0xBEEF; dbg_rvalid stays 0.
- Both req every cycle, dbg_lock=0, reading addrs 1 (CPU) and 2 (DBG):
  - Grants alternate CPU, DBG, CPU, … from reset.
  - rvalid alternates on the following cycles with the correct data.
- DBG lock with MAX_LOCK=4, both requesting continuously:
  - DBG granted 4 cycles, then CPU exactly once, then DBG re-locks.
  - Pattern repeats D,D,D,D,C.
- DBG lock, then dbg_lock dropped after 2 grants while CPU is requesting:
  - Returns to ARB; CPU is granted on the next cycle.
- Reset asserted the cycle after a DBG read grant:
  - dbg_rvalid never asserts.
  - All outputs are 0 immediately (asynchronously).
  - After release, the first conflict goes to CPU.
- Sweep DBG reads over addr 0..2047 with dbg_lock=1, CPU idle:
  - 2048 consecutive dbg_rvalid pulses, in order, no gaps.
  - Lock counter exits and re-enters every MAX_LOCK grants without losing a slot.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory arbiter: lock FSM encoding and requester ids.
package mem_arb_pkg;

    typedef enum logic {
        ARB        = 1'b0,
        DBG_LOCKED = 1'b1
    } arb_state_e;

    // Requester ids double as bit positions in the req/gnt pair.
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/rr_grant2.sv
// Two-way round-robin grant. The CPU can be masked out while DBG holds a burst lock.
module rr_grant2
    import mem_arb_pkg::*;
(
    input  logic       en,        // low forces no grant (held in reset)
    input  logic [1:0] req,       // indexed by REQ_CPU / REQ_DBG
    input  logic       prio,      // side that wins a conflict
    input  logic       block_cpu, // burst lock active: only DBG may be granted
    output logic [1:0] gnt
);

    // One-hot (or zero) grant from request, priority pointer and lock mask.
    always_comb begin
        gnt = '0;
        if (en) begin
            if (block_cpu) begin
                gnt[REQ_DBG] = req[REQ_DBG];
            end else if (req[REQ_CPU] && req[REQ_DBG]) begin
                gnt[prio] = 1'b1;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port data RAM between the CPU load/store unit and the
// debug unit, with a bounded DBG burst lock and a one-stage read-tag pipe.
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 16,
    parameter int MAX_LOCK = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_w_data,
    input  logic [DATA_W-1:0] mem_r_data
);

    localparam int LCW = $clog2(MAX_LOCK + 1);

    arb_state_e        state, state_nxt;
    logic              rr_ptr, rr_ptr_nxt;
    logic [LCW-1:0]    lock_cnt, lock_cnt_nxt, cnt_inc;
    logic              rtag_valid, rtag;
    logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
    logic [1:0]        req, gnt;

    assign req = {dbg_req, cpu_req};

    // Grants are gated by reset so every output drops asynchronously.
    rr_grant2 u_rr (
        .en        (!reset),
        .req       (req),
        .prio      (rr_ptr),
        .block_cpu (state == DBG_LOCKED),
        .gnt       (gnt)
    );

    assign cpu_gnt = gnt[REQ_CPU];
    assign dbg_gnt = gnt[REQ_DBG];

    // Steer the granted requester onto the RAM bus; idle bus is all zero.
    always_comb begin
        mem_wr_en  = 1'b0;
        mem_rd_en  = 1'b0;
        mem_addr   = '0;
        mem_w_data = '0;
        if (cpu_gnt) begin
            mem_wr_en  = cpu_we;
            mem_rd_en  = !cpu_we;
            mem_addr   = cpu_addr;
            mem_w_data = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_wr_en  = dbg_we;
            mem_rd_en  = !dbg_we;
            mem_addr   = dbg_addr;
            mem_w_data = dbg_wdata;
        end
    end

    // Lock FSM next state: round-robin pointer update, burst entry/exit and bound.
    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        lock_cnt_nxt = lock_cnt;
        cnt_inc      = lock_cnt + LCW'(1);
        case (state)
            ARB: begin
                if (cpu_gnt) rr_ptr_nxt = REQ_DBG;
                if (dbg_gnt) begin
                    rr_ptr_nxt = REQ_CPU;
                    // A bound of one grant means the lock never outlives its entry grant.
                    if (dbg_lock && MAX_LOCK > 1) begin
                        state_nxt    = DBG_LOCKED;
                        lock_cnt_nxt = LCW'(1);
                    end
                end
            end
            DBG_LOCKED: begin
                if (dbg_gnt) lock_cnt_nxt = cnt_inc;
                // Release on lock drop, or force the CPU a slot once the bound is hit.
                if (!dbg_lock || (dbg_gnt && cnt_inc == LCW'(MAX_LOCK))) begin
                    state_nxt    = ARB;
                    lock_cnt_nxt = '0;
                    rr_ptr_nxt   = REQ_CPU;
                end
            end
        endcase
    end

    // Lock FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ARB;
            rr_ptr   <= REQ_CPU;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    // Read-tag pipe: remember who issued the read the RAM is answering next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rtag_valid <= 1'b0;
            rtag       <= REQ_CPU;
        end else begin
            rtag_valid <= (cpu_gnt && !cpu_we) || (dbg_gnt && !dbg_we);
            rtag       <= dbg_gnt;
        end
    end

    assign cpu_rvalid = rtag_valid && (rtag == REQ_CPU);
    assign dbg_rvalid = rtag_valid && (rtag == REQ_DBG);

    // Hold each side's last read data so the other side's traffic doesn't disturb it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            if (cpu_rvalid) cpu_rdata_q <= mem_r_data;
            if (dbg_rvalid) dbg_rdata_q <= mem_r_data;
        end
    end

    // RAM data passes straight through in the rvalid cycle, no extra latency.
    assign cpu_rdata = cpu_rvalid ? mem_r_data : cpu_rdata_q;
    assign dbg_rdata = dbg_rvalid ? mem_r_data : dbg_rdata_q;

endmodule
